wr_burst_sequencer: RTL and testbench
=====================================

# wr_burst_sequencer

Sequences one complete DDR SDRAM write transaction: ACTIVE, tRCD wait, WRITE with auto-precharge, a double-data-rate data burst, then write-recovery and precharge waits. Sits directly upstream of the pad/command-encode stage and drives CKE/RAS/CAS/WE/BA/ADDR plus rise/fall data words. The host side is a single request handshake plus a first-word-fall-through data pop interface.

## Interface
- T_RCD, 3, ACTIVE-to-WRITE spacing in clocks (legal ≥1)
- T_WR, 2, clocks from last data cycle to start of precharge window (legal ≥1)
- T_RP, 3, precharge window in clocks (legal ≥1)
- BL, 4, burst length in beats (legal 2, 4, 8); data occupies BL/2 clocks
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- REQ  in  1  write request, sampled when READY=1
- ROW  in  13  row address, captured on accept
- COL  in  10  column address, captured on accept
- BANK  in  2  bank, captured on accept
- WR_DATA  in  32  {rise[31:16], fall[15:0]} pair, valid whenever WR_DATA_POP=1
- READY  out  1  idle, able to accept REQ
- WR_DATA_POP  out  1  WR_DATA consumed at this edge
- DONE  out  1  one-cycle pulse, transaction complete
- CKE, RAS, CAS, WE  out  1 each  SDRAM command pins
- BA  out  2  bank address
- ADDR  out  13  address bus
- DQ_RISE, DQ_FALL  out  16 each  data words for rising/falling half of CLK
- DQ_OE, DQS_OE  out  1 each  data and strobe output enables

## Operation
- States: IDLE, ACT, RCD_WAIT, WRITE, DATA, WR_REC, RP_WAIT, DONE; one down-counter reloaded per state.
- All outputs registered. Command encodings: NOP = RAS1 CAS1 WE1; ACTIVE = RAS0 CAS1 WE1, BA=BANK, ADDR=ROW; WRITE = RAS1 CAS0 WE0, BA=BANK, ADDR[9:0]=COL, ADDR[10]=1 (auto-precharge), ADDR[12:11]=0.
- CKE=1 at all times after reset.
- IDLE: READY=1; REQ=1 at edge A latches ROW/COL/BANK, READY drops.
- ACT one cycle, RCD_WAIT T_RCD-1 NOP cycles, WRITE one cycle, DATA BL/2 cycles, WR_REC T_WR NOP cycles, RP_WAIT T_RP-1 NOP cycles, DONE one cycle, then IDLE.
- DATA cycles: DQ_RISE/DQ_FALL = the WR_DATA pair popped in the previous cycle; DQ_OE=1.
- DQS_OE=1 from WRITE cycle (preamble) through last DATA cycle.
- Outside DATA cycles DQ_RISE/DQ_FALL hold 0, DQ_OE=0.
- REQ while READY=0 ignored; not queued.
- Reset: READY=0 during reset cycle then 1; CKE=1, NOP, BA=0, ADDR=0, DQ_*=0, DQ_OE=DQS_OE=0, WR_DATA_POP=0, DONE=0.
- Reset mid-transaction: next cycle outputs NOP/idle values, no DONE pulse, no further pops.

## Timing
Relative to accept edge A (cycle numbers are when values are visible on outputs):
- ACTIVE at A+1.
- WRITE at A+1+T_RCD.
- WR_DATA_POP=1 in cycles A+1+T_RCD … A+T_RCD+BL/2 (exactly BL/2 pops).
- Data at A+2+T_RCD … A+1+T_RCD+BL/2.
- DONE at A+1+T_RCD+BL/2+T_WR+T_RP.
- READY=1 the cycle after DONE; back-to-back REQ accepted there.
- Defaults give ACT A+1, WRITE A+4, pops A+4–A+5, data A+5–A+6, DONE A+11, READY A+12.

## Test plan
- Reset release, REQ=0 for 10 cycles -> READY=1, CKE=1, RAS=CAS=WE=1, DQ_OE=DQS_OE=0, no POP/DONE.
- Defaults, REQ with ROW=0x1ABC, COL=0x2F5, BANK=2; WR_DATA pairs 0x11112222 then 0x33334444 -> ACT at A+1 (ADDR=0x1ABC, BA=2), WRITE at A+4 (ADDR=0x06F5, BA=2), DQ_RISE/FALL 0x1111/0x2222 at A+5 and 0x3333/0x4444 at A+6, DONE at A+11 only.
- BL=8, T_RCD=1, T_WR=1, T_RP=1 -> WRITE at A+2, 4 pops A+2–A+5, data A+3–A+6, DONE at A+8.
- REQ held high continuously -> second ACT exactly at DONE+2; REQ toggles during busy have no effect.
- RST asserted in the cycle after WRITE (first data cycle) -> next cycle NOP, DQ_OE=DQS_OE=0, POP=0, no DONE; READY=1 one cycle after RST deasserts.
- Data pattern 0xFFFF0000/0x0000FFFF alternating -> each rise/fall word appears unswapped on the correct half, with no beat dropped or duplicated.

Source files
------------

// File: rtl/wr_burst_sequencer.sv
// One DDR write transaction: ACTIVE, tRCD, WRITE with auto-precharge, data burst, tWR, tRP.
// Every output is a flop loaded from the decode of the state being entered.
module wr_burst_sequencer #(
    parameter int T_RCD = 3,
    parameter int T_WR  = 2,
    parameter int T_RP  = 3,
    parameter int BL    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [12:0] ROW,
    input  logic [9:0]  COL,
    input  logic [1:0]  BANK,
    input  logic [31:0] WR_DATA,
    output logic        READY,
    output logic        WR_DATA_POP,
    output logic        DONE,
    output logic        CKE,
    output logic        RAS,
    output logic        CAS,
    output logic        WE,
    output logic [1:0]  BA,
    output logic [12:0] ADDR,
    output logic [15:0] DQ_RISE,
    output logic [15:0] DQ_FALL,
    output logic        DQ_OE,
    output logic        DQS_OE
);
    localparam int CNT_W    = 8;
    localparam int RCD_LOAD = (T_RCD > 1) ? T_RCD - 2 : 0;
    localparam int RP_LOAD  = (T_RP > 1) ? T_RP - 2 : 0;
    localparam int DAT_LOAD = BL / 2 - 1;
    localparam int WR_LOAD  = T_WR - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_RCD_WAIT, S_WRITE, S_DATA, S_WR_REC, S_RP_WAIT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [9:0]         col_q, col_d;
    logic [1:0]         bank_q, bank_d;
    logic               ready_q, ready_d;
    logic               pop_q, pop_d;
    logic               done_q, done_d;
    logic               cke_q, cke_d;
    logic               ras_q, ras_d, cas_q, cas_d, we_q, we_d;
    logic [1:0]         ba_q, ba_d;
    logic [12:0]        addr_q, addr_d;
    logic [15:0]        dq_rise_q, dq_rise_d, dq_fall_q, dq_fall_d;
    logic               dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d;
    logic               accept;

    // Next state; the counter is reloaded on entry to every timed state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = ready_q && REQ;
        col_d   = accept ? COL : col_q;
        bank_d  = accept ? BANK : bank_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_ACT;
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_d = S_RCD_WAIT;
                    cnt_d   = CNT_W'(RCD_LOAD);
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_RCD_WAIT: begin
                if (cnt_q == '0) state_d = S_WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WRITE: begin
                state_d = S_DATA;
                cnt_d   = CNT_W'(DAT_LOAD);
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_REC;
                    cnt_d   = CNT_W'(WR_LOAD);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_REC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (T_RP > 1) begin
                    state_d = S_RP_WAIT;
                    cnt_d   = CNT_W'(RP_LOAD);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_RP_WAIT: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the state being entered. ACTIVE is only entered from
    // IDLE on accept, so it takes ROW/BANK straight from the request port.
    always_comb begin
        ready_d   = (state_d == S_IDLE);
        pop_d     = 1'b0;
        done_d    = 1'b0;
        cke_d     = 1'b1;
        ras_d     = 1'b1;
        cas_d     = 1'b1;
        we_d      = 1'b1;
        ba_d      = '0;
        addr_d    = '0;
        dq_rise_d = '0;
        dq_fall_d = '0;
        dq_oe_d   = 1'b0;
        dqs_oe_d  = 1'b0;
        case (state_d)
            S_ACT: begin
                ras_d  = 1'b0;
                ba_d   = BANK;
                addr_d = ROW;
            end
            S_WRITE: begin
                cas_d    = 1'b0;
                we_d     = 1'b0;
                ba_d     = bank_q;
                addr_d   = {2'b00, 1'b1, col_q};
                pop_d    = 1'b1;
                dqs_oe_d = 1'b1;
            end
            S_DATA: begin
                // Last beat was fetched by the previous cycle's pop.
                pop_d     = (cnt_d != '0);
                dq_rise_d = WR_DATA[31:16];
                dq_fall_d = WR_DATA[15:0];
                dq_oe_d   = 1'b1;
                dqs_oe_d  = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            col_q     <= '0;
            bank_q    <= '0;
            ready_q   <= 1'b0;
            pop_q     <= 1'b0;
            done_q    <= 1'b0;
            cke_q     <= 1'b1;
            ras_q     <= 1'b1;
            cas_q     <= 1'b1;
            we_q      <= 1'b1;
            ba_q      <= '0;
            addr_q    <= '0;
            dq_rise_q <= '0;
            dq_fall_q <= '0;
            dq_oe_q   <= 1'b0;
            dqs_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            bank_q    <= bank_d;
            ready_q   <= ready_d;
            pop_q     <= pop_d;
            done_q    <= done_d;
            cke_q     <= cke_d;
            ras_q     <= ras_d;
            cas_q     <= cas_d;
            we_q      <= we_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
            dq_rise_q <= dq_rise_d;
            dq_fall_q <= dq_fall_d;
            dq_oe_q   <= dq_oe_d;
            dqs_oe_q  <= dqs_oe_d;
        end
    end

    assign READY       = ready_q;
    assign WR_DATA_POP = pop_q;
    assign DONE        = done_q;
    assign CKE         = cke_q;
    assign RAS         = ras_q;
    assign CAS         = cas_q;
    assign WE          = we_q;
    assign BA          = ba_q;
    assign ADDR        = addr_q;
    assign DQ_RISE     = dq_rise_q;
    assign DQ_FALL     = dq_fall_q;
    assign DQ_OE       = dq_oe_q;
    assign DQS_OE      = dqs_oe_q;
endmodule

// File: tb/tb_wr_burst_sequencer.sv
// Bench for wr_burst_sequencer: default timing (index 0) and BL=8/1/1/1 (index 1) run in lockstep,
// both checked every cycle against a transaction-offset model.
module tb_wr_burst_sequencer;
    localparam int MASK = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req[2];
    logic [12:0] row[2];
    logic [9:0]  col[2];
    logic [1:0]  bank[2];
    logic [31:0] wr_data[2];

    logic        ready_o[2], pop_o[2], done_o[2], cke_o[2];
    logic        ras_o[2], cas_o[2], we_o[2], dq_oe_o[2], dqs_oe_o[2];
    logic [1:0]  ba_o[2];
    logic [12:0] addr_o[2];
    logic [15:0] dqr_o[2], dqf_o[2];

    wr_burst_sequencer dut0 (
        .CLK(clk), .RST(rst), .REQ(req[0]), .ROW(row[0]), .COL(col[0]), .BANK(bank[0]),
        .WR_DATA(wr_data[0]), .READY(ready_o[0]), .WR_DATA_POP(pop_o[0]), .DONE(done_o[0]),
        .CKE(cke_o[0]), .RAS(ras_o[0]), .CAS(cas_o[0]), .WE(we_o[0]), .BA(ba_o[0]),
        .ADDR(addr_o[0]), .DQ_RISE(dqr_o[0]), .DQ_FALL(dqf_o[0]), .DQ_OE(dq_oe_o[0]),
        .DQS_OE(dqs_oe_o[0])
    );

    wr_burst_sequencer #(.T_RCD(1), .T_WR(1), .T_RP(1), .BL(8)) dut1 (
        .CLK(clk), .RST(rst), .REQ(req[1]), .ROW(row[1]), .COL(col[1]), .BANK(bank[1]),
        .WR_DATA(wr_data[1]), .READY(ready_o[1]), .WR_DATA_POP(pop_o[1]), .DONE(done_o[1]),
        .CKE(cke_o[1]), .RAS(ras_o[1]), .CAS(cas_o[1]), .WE(we_o[1]), .BA(ba_o[1]),
        .ADDR(addr_o[1]), .DQ_RISE(dqr_o[1]), .DQ_FALL(dqf_o[1]), .DQ_OE(dq_oe_o[1]),
        .DQS_OE(dqs_oe_o[1])
    );

    int c_rcd[2] = '{3, 1};
    int c_wr[2]  = '{2, 1};
    int c_rp[2]  = '{3, 1};
    int c_bl[2]  = '{4, 8};

    logic [31:0] src[2][1024];
    int          sidx[2];

    bit          m_busy[2], m_ready[2];
    int          m_a[2], m_base[2], m_pops[2];
    logic [12:0] m_row[2];
    logic [9:0]  m_col[2];
    logic [1:0]  m_bank[2];
    int          s;
    bit          fix_addr;

    int          done_k[2];
    logic [12:0] act_addr[2], wr_addr[2];
    logic [31:0] first_dq[2];

    int n_chk, n_pass, n_fail;

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL dut%0d %s cycle %0d: got %0h expected %0h", d, tag, s, obs, exp);
        end
    endtask

    // Expected outputs follow from the offset k of the current cycle from the accept edge.
    task automatic check(input int d);
        int k, t, h, L;
        bit act, wr, pop, dat, dqs, dn;
        logic [31:0] w;
        k = 0; act = 0; wr = 0; pop = 0; dat = 0; dqs = 0; dn = 0;
        t = c_rcd[d];
        h = c_bl[d] / 2;
        L = 1 + t + h + c_wr[d] + c_rp[d];
        if (rst) m_busy[d] = 0;
        else if (m_busy[d]) begin
            k = s - m_a[d];
            if (k > L) m_busy[d] = 0;
        end
        if (m_busy[d]) begin
            act = (k == 1);
            wr  = (k == 1 + t);
            pop = (k >= 1 + t) && (k <= t + h);
            dat = (k >= 2 + t) && (k <= 1 + t + h);
            dqs = (k >= 1 + t) && (k <= 1 + t + h);
            dn  = (k == L);
        end
        m_ready[d] = !rst && !m_busy[d];
        w = dat ? src[d][(m_base[d] + k - 2 - t) & MASK] : 32'h0;

        chk(d, "ready",  ready_o[d],  m_ready[d]);
        chk(d, "pop",    pop_o[d],    pop);
        chk(d, "done",   done_o[d],   dn);
        chk(d, "cke",    cke_o[d],    1'b1);
        chk(d, "ras",    ras_o[d],    !act);
        chk(d, "cas",    cas_o[d],    !wr);
        chk(d, "we",     we_o[d],     !wr);
        chk(d, "dq_oe",  dq_oe_o[d],  dat);
        chk(d, "dqs_oe", dqs_oe_o[d], dqs);
        chk(d, "dq_rise", dqr_o[d],   w[31:16]);
        chk(d, "dq_fall", dqf_o[d],   w[15:0]);
        if (rst) begin
            chk(d, "ba_rst",   ba_o[d],   2'd0);
            chk(d, "addr_rst", addr_o[d], 13'd0);
        end else if (act) begin
            chk(d, "ba_act",   ba_o[d],   m_bank[d]);
            chk(d, "addr_act", addr_o[d], m_row[d]);
        end else if (wr) begin
            chk(d, "ba_wr",   ba_o[d],   m_bank[d]);
            chk(d, "addr_wr", addr_o[d], {3'b001, m_col[d]});
        end

        if (m_busy[d] && done_o[d] === 1'b1) done_k[d] = k;
        if (act) act_addr[d] = addr_o[d];
        if (wr)  wr_addr[d]  = addr_o[d];
        if (m_busy[d] && k == 2 + t) first_dq[d] = {dqr_o[d], dqf_o[d]};
        if (pop) m_pops[d]++;
    endtask

    task automatic step(input logic rst_v, input logic [1:0] rq);
        logic psn[2];
        @(negedge clk);
        s++;
        for (int d = 0; d < 2; d++) check(d);
        for (int d = 0; d < 2; d++) psn[d] = pop_o[d];
        rst = rst_v;
        for (int d = 0; d < 2; d++) begin
            req[d] = rq[d];
            if (!fix_addr) begin
                row[d]  = 13'($urandom);
                col[d]  = 10'($urandom);
                bank[d] = 2'($urandom);
            end
            if (m_ready[d] && rq[d] && !rst_v) begin
                m_busy[d] = 1;
                m_a[d]    = s;
                m_base[d] = m_pops[d];
                m_row[d]  = row[d];
                m_col[d]  = col[d];
                m_bank[d] = bank[d];
            end
        end
        @(posedge clk);
        #1;
        // FWFT source: advance past a word the DUT popped at this edge.
        for (int d = 0; d < 2; d++)
            if (psn[d] === 1'b1) begin
                sidx[d]    = (sidx[d] + 1) & MASK;
                wr_data[d] = src[d][sidx[d]];
            end
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0; s = 0; fix_addr = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) begin
                if (i < 2)       src[d][i] = $urandom;
                else if (i < 64) src[d][i] = (i % 2 == 0) ? 32'hFFFF0000 : 32'h0000FFFF;
                else             src[d][i] = $urandom;
            end
            sidx[d] = 0; m_busy[d] = 0; m_ready[d] = 0; m_pops[d] = 0;
            m_a[d] = 0; m_base[d] = 0; done_k[d] = -1;
            req[d] = 0; row[d] = '0; col[d] = '0; bank[d] = '0;
        end
        src[0][0] = 32'h11112222;
        src[0][1] = 32'h33334444;
        wr_data[0] = src[0][0];
        wr_data[1] = src[1][0];
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then idle with REQ low.
        step(1'b1, 2'b00);
        step(1'b1, 2'b00);
        repeat (10) step(1'b0, 2'b00);

        // Directed single transaction on both configurations.
        fix_addr = 1;
        row[0] = 13'h1ABC; col[0] = 10'h2F5; bank[0] = 2'd2;
        row[1] = 13'h0555; col[1] = 10'h1AA; bank[1] = 2'd1;
        step(1'b0, 2'b11);
        fix_addr = 0;
        repeat (14) step(1'b0, 2'b00);
        chk(0, "act_addr_dir",  32'(act_addr[0]), 32'h1ABC);
        chk(0, "wr_addr_dir",   32'(wr_addr[0]),  32'h06F5);
        chk(0, "first_beat",    first_dq[0],      32'h11112222);
        chk(0, "done_latency",  done_k[0],        11);
        chk(1, "wr_addr_dir",   32'(wr_addr[1]),  32'h05AA);
        chk(1, "done_latency",  done_k[1],        8);

        // REQ held high, then toggled at random while busy.
        repeat (40) step(1'b0, 2'b11);
        repeat (60) step(1'b0, 2'($urandom));

        // Reset asserted in the first data cycle of a default-timing transaction.
        repeat (14) step(1'b0, 2'b00);
        step(1'b0, 2'b01);
        repeat (4) step(1'b0, 2'b00);
        step(1'b1, 2'b00);
        repeat (6) step(1'b0, 2'b00);

        // Random traffic.
        repeat (300) step(1'b0, ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom));
        repeat (16) step(1'b0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
